// File: rtl/decode_unit_pkg.sv
// Shared encodings for the decode stage: opcode/funct constants, exact-match
// system instructions, pipeline flush codes and fence FSM state types.
package decode_unit_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_FENCE   = 3'b000;
    localparam logic [2:0] F3_FENCE_I = 3'b001;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // SFENCE.VMA: funct7=0001001, rs1/rs2 free, funct3=000, rd=0
    localparam logic [31:0] SFENCE_VMA_MASK  = 32'hFE00_7FFF;
    localparam logic [31:0] SFENCE_VMA_MATCH = 32'h1200_0073;

    localparam logic [3:0] FLUSH_EARLY = 4'h1;
    localparam logic [3:0] FLUSH_ALL   = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } fence_state_e;

    typedef enum logic [1:0] {
        FK_FENCE   = 2'd0,
        FK_FENCE_I = 2'd1,
        FK_SFENCE  = 2'd2
    } fence_kind_e;

endpackage

// File: rtl/decode_unit_inst_legality.sv
// Combinational RV32I(+M) legality check and instruction-class flags.
module inst_legality
    import decode_unit_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0] inst_i,
    output logic        invalid_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        ecall_o,
    output logic        mret_o,
    output logic        fence_o,
    output logic        fence_i_o,
    output logic        sfence_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    always_comb begin
        legal      = 1'b0;
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        ecall_o    = 1'b0;
        mret_o     = 1'b0;
        fence_o    = 1'b0;
        fence_i_o  = 1'b0;
        sfence_o   = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            OPC_JALR:   legal = (funct3 == 3'b000);
            OPC_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            OPC_LOAD: begin
                legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                is_load_o = legal;
            end
            OPC_STORE: begin
                legal      = (funct3 <= 3'b010);
                is_store_o = legal;
            end
            OPC_OP_IMM: begin
                // shift-immediates reuse imm[11:5] as funct7
                case (funct3)
                    3'b001:  legal = (funct7 == F7_BASE);
                    3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE)
                    legal = 1'b1;
                else if (funct7 == F7_ALT)
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                else if (funct7 == F7_MEXT)
                    legal = (ENABLE_M != 0);
            end
            OPC_MISC_MEM: begin
                fence_o   = (funct3 == F3_FENCE);
                fence_i_o = (funct3 == F3_FENCE_I);
                legal     = fence_o || fence_i_o;
            end
            OPC_SYSTEM: begin
                if (funct3 != 3'b000) begin
                    legal = (funct3 != 3'b100);
                end else begin
                    ecall_o  = (inst_i == INST_ECALL);
                    mret_o   = (inst_i == INST_MRET);
                    sfence_o = ((inst_i & SFENCE_VMA_MASK) == SFENCE_VMA_MATCH);
                    legal    = ecall_o || mret_o || sfence_o || (inst_i == INST_EBREAK);
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign invalid_o = !legal;

endmodule

// File: rtl/decode_unit.sv
// RV32 decode stage: registered decode behind valid/ready, fence serialisation
// with a drain window and cache/TLB flush handshake, and pipeline flush.
module decode_unit
    import decode_unit_pkg::*;
#(
    parameter int FENCE_STALL_CYCLES = 8,
    parameter int ENABLE_M           = 1,
    parameter int CNT_W              = $clog2(FENCE_STALL_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  hazard_signal,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_csr_inst,
    output logic        out_invalid,
    output logic        out_is_load,
    output logic        out_is_store,
    output logic        out_ecall,
    output logic        out_mret,
    output logic        fence_active,
    input  logic        mem_idle,
    output logic        icache_flush_req,
    output logic        tlb_flush_req,
    input  logic        flush_ack
);

    logic dec_invalid, dec_load, dec_store, dec_ecall, dec_mret;
    logic dec_fence, dec_fence_i, dec_sfence, dec_fence_any;

    inst_legality #(.ENABLE_M(ENABLE_M)) u_legality (
        .inst_i     (in_inst),
        .invalid_o  (dec_invalid),
        .is_load_o  (dec_load),
        .is_store_o (dec_store),
        .ecall_o    (dec_ecall),
        .mret_o     (dec_mret),
        .fence_o    (dec_fence),
        .fence_i_o  (dec_fence_i),
        .sfence_o   (dec_sfence)
    );

    fence_state_e     state_q;
    fence_kind_e      kind_q;
    logic [CNT_W-1:0] cnt_q;
    logic             icache_req_q, tlb_req_q;

    logic        valid_q;
    logic [31:0] inst_q, pc_q, csr_inst_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        invalid_q, load_q, store_q, ecall_q, mret_q;

    logic        flush, accept, is_system;
    logic [4:0]  rs2_d;
    logic [31:0] csr_inst_d;

    assign flush         = (hazard_signal == FLUSH_EARLY) || (hazard_signal == FLUSH_ALL);
    assign in_ready      = !rst && !flush && (state_q == ST_IDLE) && (!valid_q || out_ready);
    assign accept        = in_valid && in_ready;
    assign dec_fence_any = dec_fence || dec_fence_i || dec_sfence;
    assign fence_active  = (state_q != ST_IDLE) || (in_valid && dec_fence_any);

    assign is_system  = (in_inst[6:0] == OPC_SYSTEM);
    assign rs2_d      = is_system ? 5'd0 : in_inst[24:20];
    assign csr_inst_d = is_system ? in_inst : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
            csr_inst_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            invalid_q  <= 1'b0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            ecall_q    <= 1'b0;
            mret_q     <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            inst_q     <= in_inst;
            pc_q       <= in_pc;
            csr_inst_q <= csr_inst_d;
            rs1_q      <= in_inst[19:15];
            rs2_q      <= rs2_d;
            rd_q       <= in_inst[11:7];
            invalid_q  <= dec_invalid;
            load_q     <= dec_load;
            store_q    <= dec_store;
            ecall_q    <= dec_ecall;
            mret_q     <= dec_mret;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Drain counter stops at 1 and waits there for mem_idle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q      <= ST_IDLE;
            kind_q       <= FK_FENCE;
            cnt_q        <= '0;
            icache_req_q <= 1'b0;
            tlb_req_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && dec_fence_any) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_W'(FENCE_STALL_CYCLES);
                        kind_q  <= dec_fence_i ? FK_FENCE_I :
                                   dec_sfence  ? FK_SFENCE  : FK_FENCE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q != CNT_W'(1)) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (mem_idle) begin
                        cnt_q        <= '0;
                        state_q      <= (kind_q == FK_FENCE) ? ST_IDLE : ST_FLUSH;
                        icache_req_q <= (kind_q == FK_FENCE_I);
                        tlb_req_q    <= (kind_q == FK_SFENCE);
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        state_q      <= ST_IDLE;
                        icache_req_q <= 1'b0;
                        tlb_req_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid        = valid_q;
    assign out_inst         = inst_q;
    assign out_pc           = pc_q;
    assign out_rs1          = rs1_q;
    assign out_rs2          = rs2_q;
    assign out_rd           = rd_q;
    assign out_csr_inst     = csr_inst_q;
    assign out_invalid      = invalid_q;
    assign out_is_load      = load_q;
    assign out_is_store     = store_q;
    assign out_ecall        = ecall_q;
    assign out_mret         = mret_q;
    assign icache_flush_req = icache_req_q;
    assign tlb_flush_req    = tlb_req_q;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: a table-driven reference decoder plus a cycle model
// checked every negedge, and directed scenarios with literal expectations.
module tb_decode_unit;
    import decode_unit_pkg::*;

    localparam int F = 8;

    logic        clk, rst;
    logic [3:0]  hazard_signal;
    logic        in_valid, out_ready, mem_idle, flush_ack;
    logic [31:0] in_inst, in_pc;

    logic        in_ready, out_valid, out_invalid, out_is_load, out_is_store;
    logic        out_ecall, out_mret, fence_active, icache_flush_req, tlb_flush_req;
    logic [31:0] out_inst, out_pc, out_csr_inst;
    logic [4:0]  out_rs1, out_rs2, out_rd;

    logic        n_in_ready, n_out_valid, n_out_invalid, n_out_is_load, n_out_is_store;
    logic        n_out_ecall, n_out_mret, n_fence_active, n_icache_flush_req, n_tlb_flush_req;
    logic [31:0] n_out_inst, n_out_pc, n_out_csr_inst;
    logic [4:0]  n_out_rs1, n_out_rs2, n_out_rd;

    decode_unit #(.FENCE_STALL_CYCLES(F), .ENABLE_M(1)) dut (
        .clk(clk), .rst(rst), .hazard_signal(hazard_signal),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_csr_inst(out_csr_inst),
        .out_invalid(out_invalid), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_ecall(out_ecall), .out_mret(out_mret), .fence_active(fence_active),
        .mem_idle(mem_idle), .icache_flush_req(icache_flush_req),
        .tlb_flush_req(tlb_flush_req), .flush_ack(flush_ack)
    );

    decode_unit #(.FENCE_STALL_CYCLES(F), .ENABLE_M(0)) dut_nom (
        .clk(clk), .rst(rst), .hazard_signal(hazard_signal),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_inst(n_out_inst), .out_pc(n_out_pc),
        .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd), .out_csr_inst(n_out_csr_inst),
        .out_invalid(n_out_invalid), .out_is_load(n_out_is_load), .out_is_store(n_out_is_store),
        .out_ecall(n_out_ecall), .out_mret(n_out_mret), .fence_active(n_fence_active),
        .mem_idle(mem_idle), .icache_flush_req(n_icache_flush_req),
        .tlb_flush_req(n_tlb_flush_req), .flush_ack(flush_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decoder: list of legal (mask, match) patterns.
    // kind: 0 plain, 1 load, 2 store, 3 ecall, 4 mret, 5 fence, 6 fence.i, 7 sfence.vma, 8 M-ext
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          kind;
    } pat_t;
    pat_t pats[$];

    typedef struct packed {
        logic       legal, load, store, ecall, mret, fclass;
        logic [3:0] kind;
    } ref_t;

    task automatic add_pat(input logic [31:0] mask, input logic [31:0] match, input int kind);
        pat_t p;
        p.mask = mask; p.match = match; p.kind = kind;
        pats.push_back(p);
    endtask

    task automatic build_pats();
        int br[6]  = '{0, 1, 4, 5, 6, 7};
        int ld[5]  = '{0, 1, 2, 4, 5};
        int imm[6] = '{0, 2, 3, 4, 6, 7};
        int csr[6] = '{1, 2, 3, 5, 6, 7};
        add_pat(32'h7F, 32'h37, 0);
        add_pat(32'h7F, 32'h17, 0);
        add_pat(32'h7F, 32'h6F, 0);
        add_pat(32'h707F, 32'h67, 0);
        foreach (br[i])  add_pat(32'h707F, 32'h63 | (br[i] << 12), 0);
        foreach (ld[i])  add_pat(32'h707F, 32'h03 | (ld[i] << 12), 1);
        for (int i = 0; i < 3; i++) add_pat(32'h707F, 32'h23 | (i << 12), 2);
        foreach (imm[i]) add_pat(32'h707F, 32'h13 | (imm[i] << 12), 0);
        foreach (csr[i]) add_pat(32'h707F, 32'h73 | (csr[i] << 12), 0);
        add_pat(32'h707F, 32'h0F, 5);
        add_pat(32'h707F, 32'h100F, 6);
        add_pat(32'hFE00707F, 32'h00001013, 0);
        add_pat(32'hFE00707F, 32'h00005013, 0);
        add_pat(32'hFE00707F, 32'h40005013, 0);
        for (int i = 0; i < 8; i++) add_pat(32'hFE00707F, 32'h33 | (i << 12), 0);
        add_pat(32'hFE00707F, 32'h40000033, 0);
        add_pat(32'hFE00707F, 32'h40005033, 0);
        for (int i = 0; i < 8; i++) add_pat(32'hFE00707F, 32'h02000033 | (i << 12), 8);
        add_pat(32'hFFFFFFFF, 32'h00000073, 3);
        add_pat(32'hFFFFFFFF, 32'h00100073, 0);
        add_pat(32'hFFFFFFFF, 32'h30200073, 4);
        add_pat(32'hFE007FFF, 32'h12000073, 7);
    endtask

    function automatic ref_t ref_decode(input logic [31:0] w, input bit m_en);
        ref_t r = '0;
        foreach (pats[i]) begin
            if (((w & pats[i].mask) == pats[i].match) && (pats[i].kind != 8 || m_en)) begin
                r.legal  = 1'b1;
                r.load   = (pats[i].kind == 1);
                r.store  = (pats[i].kind == 2);
                r.ecall  = (pats[i].kind == 3);
                r.mret   = (pats[i].kind == 4);
                r.fclass = (pats[i].kind >= 5) && (pats[i].kind <= 7);
                r.kind   = 4'(pats[i].kind);
            end
        end
        return r;
    endfunction

    // Cycle model. mode: 0 idle, 1 draining, 2 waiting for flush ack.
    logic        m_vld, m_inv, m_inv_nom, m_ld, m_st, m_ec, m_mr, m_reqi, m_reqt;
    logic [31:0] m_inst, m_pc;
    int          m_mode, m_kind, m_elapsed;

    initial begin
        m_vld = 0; m_inv = 0; m_inv_nom = 0; m_ld = 0; m_st = 0; m_ec = 0; m_mr = 0;
        m_reqi = 0; m_reqt = 0; m_inst = 0; m_pc = 0; m_mode = 0; m_kind = 0; m_elapsed = 0;
    end

    always @(negedge clk) begin
        ref_t  r_in;
        logic  flsh, exp_rdy, exp_fa, acc, sys;
        r_in    = ref_decode(in_inst, 1'b1);
        flsh    = (hazard_signal == FLUSH_EARLY) || (hazard_signal == FLUSH_ALL);
        exp_rdy = !rst && !flsh && (m_mode == 0) && (!m_vld || out_ready);
        exp_fa  = (m_mode != 0) || (in_valid && r_in.fclass);
        sys     = (m_inst[6:0] == 7'h73);

        chk("in_ready", in_ready, exp_rdy);
        chk("fence_active", fence_active, exp_fa);
        chk("out_valid", out_valid, m_vld);
        chk("icache_flush_req", icache_flush_req, m_reqi);
        chk("tlb_flush_req", tlb_flush_req, m_reqt);
        chk("out_inst", out_inst, m_inst);
        chk("out_pc", out_pc, m_pc);
        chk("out_rs1", out_rs1, m_inst[19:15]);
        chk("out_rd", out_rd, m_inst[11:7]);
        chk("out_rs2", out_rs2, sys ? 5'd0 : m_inst[24:20]);
        chk("out_csr_inst", out_csr_inst, sys ? m_inst : 32'd0);
        chk("out_invalid", out_invalid, m_inv);
        chk("out_invalid_nom", n_out_invalid, m_inv_nom);
        chk("out_is_load", out_is_load, m_ld);
        chk("out_is_store", out_is_store, m_st);
        chk("out_ecall", out_ecall, m_ec);
        chk("out_mret", out_mret, m_mr);

        acc = in_valid && exp_rdy;
        if (rst) begin
            m_vld = 0; m_inv = 0; m_inv_nom = 0; m_ld = 0; m_st = 0; m_ec = 0; m_mr = 0;
            m_inst = 0; m_pc = 0; m_mode = 0; m_reqi = 0; m_reqt = 0;
        end else if (flsh) begin
            m_vld = 0; m_mode = 0; m_reqi = 0; m_reqt = 0;
        end else begin
            if (m_mode == 0) begin
                if (acc && r_in.fclass) begin
                    m_mode = 1; m_kind = int'(r_in.kind); m_elapsed = 0;
                end
            end else if (m_mode == 1) begin
                m_elapsed++;
                if (m_elapsed >= F && mem_idle) begin
                    m_mode = (m_kind == 5) ? 0 : 2;
                    m_reqi = (m_kind == 6);
                    m_reqt = (m_kind == 7);
                end
            end else if (flush_ack) begin
                m_mode = 0; m_reqi = 0; m_reqt = 0;
            end
            if (acc) begin
                m_vld = 1; m_inst = in_inst; m_pc = in_pc;
                m_inv = !r_in.legal; m_inv_nom = !ref_decode(in_inst, 1'b0).legal;
                m_ld = r_in.load; m_st = r_in.store; m_ec = r_in.ecall; m_mr = r_in.mret;
            end else if (out_ready) begin
                m_vld = 0;
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        int waited = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_inst = w; in_pc = pc;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("send_accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic measure_ready_low(input int release_at, output int cnt);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            @(posedge clk); #1;
            if (cnt == release_at) mem_idle = 1'b1;
        end
    endtask

    task automatic wait_req(input bit tlb, output int cnt);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tlb ? tlb_flush_req : icache_flush_req) break;
            cnt++;
        end
    endtask

    logic [31:0] burst [12] = '{
        32'h40005013, 32'h40001013, 32'h00002063, 32'h40000033, 32'h0220C0B3,
        32'h00100073, 32'h00000073, 32'h30200073, 32'h12345037, 32'h0000C083,
        32'h0FF0000F, 32'h00008067
    };

    initial begin
        int cnt;
        int idx;
        build_pats();
        rst = 1; hazard_signal = 0; in_valid = 0; in_inst = 0; in_pc = 0;
        out_ready = 1; mem_idle = 1; flush_ack = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1'b1);

        send(32'h003100B3, 32'h100);
        @(negedge clk);
        chk("add_valid", out_valid, 1'b1);
        chk("add_rs1", out_rs1, 5'd2);
        chk("add_rs2", out_rs2, 5'd3);
        chk("add_rd", out_rd, 5'd1);
        chk("add_invalid", out_invalid, 1'b0);

        send(32'h30529073, 32'h104);
        @(negedge clk);
        chk("csrrw_rs2", out_rs2, 5'd0);
        chk("csrrw_csr_inst", out_csr_inst, 32'h30529073);

        send(32'h00000000, 32'h108);
        @(negedge clk);
        chk("zero_invalid", out_invalid, 1'b1);

        send(32'h022080B3, 32'h10C);
        @(negedge clk);
        chk("mul_m1_invalid", out_invalid, 1'b0);
        chk("mul_m0_invalid", n_out_invalid, 1'b1);

        send(32'h0FF0000F, 32'h110);
        measure_ready_low(0, cnt);
        chk("fence_stall_len", cnt, 8);

        mem_idle = 0;
        send(32'h0FF0000F, 32'h114);
        measure_ready_low(12, cnt);
        chk("fence_stall_memidle_len", cnt, 13);

        send(32'h0000100F, 32'h118);
        wait_req(1'b0, cnt);
        chk("fencei_req_delay", cnt, 8);
        repeat (3) @(posedge clk);
        #1 flush_ack = 1;
        @(negedge clk);
        chk("fencei_req_held", icache_flush_req, 1'b1);
        @(posedge clk); #1 flush_ack = 0;
        @(negedge clk);
        chk("fencei_req_dropped", icache_flush_req, 1'b0);
        chk("fencei_idle_ready", in_ready, 1'b1);

        send(32'h12000073, 32'h11C);
        wait_req(1'b1, cnt);
        chk("sfence_req_delay", cnt, 8);
        @(posedge clk); #1 flush_ack = 1;
        @(posedge clk); #1 flush_ack = 0;
        @(negedge clk);
        chk("sfence_req_dropped", tlb_flush_req, 1'b0);

        send(32'h0000100F, 32'h120);
        wait_req(1'b0, cnt);
        @(posedge clk); #1 hazard_signal = FLUSH_EARLY;
        @(posedge clk); #1 hazard_signal = 4'h0;
        @(negedge clk);
        chk("abort_flush_req", icache_flush_req, 1'b0);
        @(posedge clk); #1 flush_ack = 1;
        @(posedge clk); #1 flush_ack = 0;

        send(32'h0FF0000F, 32'h124);
        in_valid = 1; in_inst = 32'h003100B3; in_pc = 32'h128;
        repeat (3) @(posedge clk);
        #1 hazard_signal = FLUSH_ALL;
        @(posedge clk); #1 hazard_signal = 4'h0;
        @(negedge clk);
        chk("flushall_out_valid", out_valid, 1'b0);
        chk("flushall_fence_active", fence_active, 1'b0);
        @(posedge clk); #1 in_valid = 0;

        @(posedge clk); #1 out_ready = 0;
        send(32'h0000A103, 32'h200);
        in_valid = 1; in_inst = 32'h0020A023; in_pc = 32'h204;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_inst", out_inst, 32'h0000A103);
            chk("bp_hold_load", out_is_load, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("bp_new_inst", out_inst, 32'h0020A023);
        chk("bp_new_store", out_is_store, 1'b1);

        idx = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 600 && idx < 12; c++) begin
            in_valid  = 1; in_inst = burst[idx]; in_pc = 32'h300 + 32'(idx * 4);
            out_ready = (c % 3 != 2);
            @(negedge clk);
            cnt = int'(in_ready);
            @(posedge clk); #1;
            if (cnt != 0) idx++;
        end
        in_valid = 0; out_ready = 1;
        chk("burst_complete", idx, 12);

        repeat (20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
